// File: rtl/hdmi_to_blocks.sv
// Raster-to-block converter: buffers 8-line HDMI stripes in ping-pong RAMs, replays them as 8x8 blocks.
// Optional line-count check per frame is compiled in with HTB_FRAME_CHECK_EN.
module hdmi_to_blocks #(
   parameter int N     = 2,
   parameter int X_RES = 2160,
   parameter int Y_RES = 1200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hdmi_v_sync,
   input  logic                    hdmi_h_sync,
   input  logic                    hdmi_data_valid,
   input  logic signed [N-1:0][7:0] hdmi_data_y,
   input  logic signed [N-1:0][7:0] hdmi_data_cr,
   input  logic signed [N-1:0][7:0] hdmi_data_cb,
   output logic                    blk_valid,
   output logic signed [N-1:0][7:0] blk_data_y,
   output logic signed [N-1:0][7:0] blk_data_cr,
   output logic signed [N-1:0][7:0] blk_data_cb,
   output logic                    blk_sob,
   output logic                    blk_eob,
   output logic                    blk_sof,
   output logic                    ovf_err,
   output logic                    frame_err
);

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int WPL     = X_RES / N;      // words per line
   localparam int DEPTH   = 8 * WPL;
   localparam int EPB     = 8 / N;          // beats per block row
   localparam int NBLK    = X_RES / 8;
   localparam int NSTRIPE = Y_RES / 8;
   localparam int PW      = 8 * N;
   localparam int WORD_W  = 3 * PW;
   localparam int AW      = cw(DEPTH);
   localparam int COL_W   = cw(WPL);
   localparam int ELEM_W  = cw(EPB);
   localparam int BLK_W   = cw(NBLK);
   localparam int SCNT_W  = cw(NSTRIPE + 2);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WPL - 1);
   localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(EPB - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NBLK - 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(NSTRIPE);

   typedef enum logic {R_IDLE, R_READ} rstate_t;

   logic unused_h_sync;
   assign unused_h_sync = hdmi_h_sync;

   // ---------------- write side ----------------
   logic              v_sync_q, armed, sof_pending, wbuf;
   logic [COL_W-1:0]  col;
   logic [2:0]        line;
   logic [SCNT_W-1:0] stripe_cnt;
   rstate_t           state;

   logic              v_rise, wr_en, stripe_last, handoff;
   logic [COL_W-1:0]  wr_col;
   logic [2:0]        wr_line;
   logic [AW-1:0]     wr_addr;
   logic [WORD_W-1:0] wr_word;

   assign v_rise = hdmi_v_sync & ~v_sync_q;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      wr_col  = v_rise ? '0 : col;
      wr_line = v_rise ? '0 : line;
      wr_en   = hdmi_data_valid && (v_rise || (armed && stripe_cnt < SCNT_MAX));
   end

   assign wr_addr     = AW'(wr_line) * AW'(WPL) + AW'(wr_col);
   assign wr_word     = {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
   assign stripe_last = wr_en && (wr_col == COL_LAST) && (wr_line == 3'd7);
   assign handoff     = stripe_last && (state == R_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         v_sync_q    <= 1'b0;
         armed       <= 1'b0;
         sof_pending <= 1'b0;
         wbuf        <= 1'b0;
         col         <= '0;
         line        <= '0;
         stripe_cnt  <= '0;
         ovf_err     <= 1'b0;
      end else begin
         v_sync_q <= hdmi_v_sync;
         if (v_rise) begin
            armed       <= 1'b1;
            sof_pending <= 1'b1;
            col         <= '0;
            line        <= '0;
            stripe_cnt  <= '0;
         end
         if (wr_en) begin
            if (wr_col == COL_LAST) begin
               col  <= '0;
               line <= wr_line + 3'd1;
            end else begin
               col  <= wr_col + 1'b1;
               line <= wr_line;
            end
            // A completed stripe is dropped if the reader is busy; the same buffer is then rewritten.
            if (stripe_last) begin
               if (state == R_IDLE) begin
                  wbuf        <= ~wbuf;
                  stripe_cnt  <= (v_rise ? '0 : stripe_cnt) + 1'b1;
                  sof_pending <= 1'b0;
               end else begin
                  ovf_err <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- ping-pong buffers ----------------
   logic [WORD_W-1:0] mem0 [DEPTH];
   logic [WORD_W-1:0] mem1 [DEPTH];
   logic [WORD_W-1:0] q0, q1;
   logic [AW-1:0]     rd_addr;

   // NOTE: the RAM arrays carry no reset; stale contents are never read before being rewritten.
   always_ff @(posedge clk) begin
      if (wr_en && !wbuf) mem0[wr_addr] <= wr_word;
      if (wr_en &&  wbuf) mem1[wr_addr] <= wr_word;
      q0 <= mem0[rd_addr];
      q1 <= mem1[rd_addr];
   end

   // ---------------- read side ----------------
   logic              rbuf, rsof;
   logic [ELEM_W-1:0] elem;
   logic [2:0]        bline;
   logic [BLK_W-1:0]  blk;

   assign rd_addr = AW'(blk) * AW'(EPB) + AW'(bline) * AW'(WPL) + AW'(elem);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= R_IDLE;
         rbuf  <= 1'b0;
         rsof  <= 1'b0;
         elem  <= '0;
         bline <= '0;
         blk   <= '0;
      end else begin
         case (state)
            R_IDLE: begin
               if (handoff) begin
                  state <= R_READ;
                  rbuf  <= wbuf;
                  rsof  <= sof_pending;
                  elem  <= '0;
                  bline <= '0;
                  blk   <= '0;
               end
            end
            R_READ: begin
               if (elem == ELEM_LAST) begin
                  elem <= '0;
                  if (bline == 3'd7) begin
                     bline <= '0;
                     if (blk == BLK_LAST) begin
                        blk   <= '0;
                        state <= R_IDLE;
                     end else begin
                        blk <= blk + 1'b1;
                     end
                  end else begin
                     bline <= bline + 3'd1;
                  end
               end else begin
                  elem <= elem + 1'b1;
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

   // ---------------- output pipeline: address -> RAM -> registers ----------------
   logic              s1_valid, s1_sob, s1_eob, s1_sof, s1_buf;
   logic              rd_sob;
   logic [WORD_W-1:0] rd_word;

   assign rd_sob  = (state == R_READ) && (elem == '0) && (bline == 3'd0);
   assign rd_word = s1_buf ? q1 : q0;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_sob      <= 1'b0;
         s1_eob      <= 1'b0;
         s1_sof      <= 1'b0;
         s1_buf      <= 1'b0;
         blk_valid   <= 1'b0;
         blk_sob     <= 1'b0;
         blk_eob     <= 1'b0;
         blk_sof     <= 1'b0;
         blk_data_y  <= '0;
         blk_data_cr <= '0;
         blk_data_cb <= '0;
      end else begin
         s1_valid    <= (state == R_READ);
         s1_sob      <= rd_sob;
         s1_eob      <= (state == R_READ) && (elem == ELEM_LAST) && (bline == 3'd7);
         s1_sof      <= rd_sob && (blk == '0) && rsof;
         s1_buf      <= rbuf;
         blk_valid   <= s1_valid;
         blk_sob     <= s1_sob;
         blk_eob     <= s1_eob;
         blk_sof     <= s1_sof;
         blk_data_y  <= s1_valid ? rd_word[PW-1:0]      : '0;
         blk_data_cr <= s1_valid ? rd_word[2*PW-1:PW]   : '0;
         blk_data_cb <= s1_valid ? rd_word[3*PW-1:2*PW] : '0;
      end
   end

   // ---------------- optional frame line-count check ----------------
`ifdef HTB_FRAME_CHECK_EN
   localparam logic [SCNT_W-1:0] DONE_SAT = SCNT_W'(NSTRIPE + 1);
   logic [SCNT_W-1:0] done_cnt;

   // Counts handed-off and dropped stripes alike; the first edge after reset only arms the check.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= v_rise && armed && (done_cnt != SCNT_MAX);
         if (v_rise)
            done_cnt <= '0;
         else if (stripe_last && done_cnt != DONE_SAT)
            done_cnt <= done_cnt + 1'b1;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule
